// File: rtl/fp_align_seq.sv
// fp_align_seq: exponent compare and mantissa alignment sequencer that feeds
// the significand adder of the binary32 adder.
// One operand pair at a time: IDLE -> CMP -> SHIFT* -> DONE -> IDLE.
// Optional build macro FP_ALIGN_FAST_SHIFT_EN: while 4 or more shift steps
// remain, SHIFT moves the mantissa by 4 bits per cycle instead of 1. Results
// are the same in both builds; only the latency changes.

// Magnitude comparator for two 8-bit unsigned values.
module comp8 (
  input  logic [7:0] a,
  input  logic [7:0] b,
  output logic       a_gt_b,
  output logic       a_lt_b
);
  assign a_gt_b = (a > b);
  assign a_lt_b = (a < b);
endmodule

module fp_align_seq #(
  parameter int SHIFT_CAP = 27  // largest shift applied; at most 255 is meaningful
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [7:0]  out_exp,
  output logic [26:0] out_big_man,
  output logic [26:0] out_small_man,
  output logic        out_big_sign,
  output logic        out_small_sign,
  output logic        out_swap
);

  localparam int RW = $clog2(SHIFT_CAP + 1);
  localparam logic [RW-1:0] CAP_W = RW'(SHIFT_CAP);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_CMP   = 2'd1,
    S_SHIFT = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t state_reg, state_next;

  logic [31:0]   a_reg, b_reg;
  logic [RW-1:0] remaining_reg;
  logic [7:0]    exp_reg;
  logic [26:0]   big_man_reg, small_man_reg;
  logic          big_sign_reg, small_sign_reg, swap_reg;

  logic [7:0]    exp_a_eff, exp_b_eff, abs_diff;
  logic [26:0]   man_a, man_b;
  logic          a_gt_b, a_lt_b;
  logic [RW-1:0] shift_k;
  logic [26:0]   shifted_man;
  logic [RW-1:0] rem_after;

  // Effective exponent and full mantissa of each latched operand; a zero
  // exponent field means subnormal (exponent 1, hidden bit 0).
  always_comb begin
    exp_a_eff = (a_reg[30:23] == 8'd0) ? 8'd1 : a_reg[30:23];
    exp_b_eff = (b_reg[30:23] == 8'd0) ? 8'd1 : b_reg[30:23];
    man_a     = {(a_reg[30:23] != 8'd0), a_reg[22:0], 3'b000};
    man_b     = {(b_reg[30:23] != 8'd0), b_reg[22:0], 3'b000};
  end

  comp8 u_comp8 (
    .a      (exp_a_eff),
    .b      (exp_b_eff),
    .a_gt_b (a_gt_b),
    .a_lt_b (a_lt_b)
  );

  // Exponent difference, saturated to the shift cap.
  always_comb begin
    abs_diff = a_gt_b ? (exp_a_eff - exp_b_eff) : (exp_b_eff - exp_a_eff);
    shift_k  = (32'(abs_diff) > SHIFT_CAP) ? CAP_W : RW'(abs_diff);
  end

  // One shift step of the small mantissa, folding discarded bits into bit 0.
  always_comb begin
    shifted_man    = {1'b0, small_man_reg[26:1]};
    shifted_man[0] = small_man_reg[1] | small_man_reg[0];
    rem_after      = remaining_reg - RW'(1);
`ifdef FP_ALIGN_FAST_SHIFT_EN
    if (remaining_reg >= RW'(4)) begin
      shifted_man    = {4'b0000, small_man_reg[26:4]};
      shifted_man[0] = |small_man_reg[4:0];
      rem_after      = remaining_reg - RW'(4);
    end
`endif
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state_reg <= S_IDLE;
    else     state_reg <= state_next;
  end

  // Next-state logic.
  always_comb begin
    state_next = state_reg;
    unique case (state_reg)
      S_IDLE:  if (in_valid)              state_next = S_CMP;
      S_CMP:   state_next = (shift_k != '0) ? S_SHIFT : S_DONE;
      S_SHIFT: if (rem_after == '0)       state_next = S_DONE;
      S_DONE:  if (out_ready)             state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  // Handshake outputs decoded from the state.
  always_comb begin
    in_ready  = (state_reg == S_IDLE);
    out_valid = (state_reg == S_DONE);
  end

  // Operand capture, compare/select and the shifting datapath.
  always_ff @(posedge clk) begin
    if (rst) begin
      a_reg          <= '0;
      b_reg          <= '0;
      remaining_reg  <= '0;
      exp_reg        <= '0;
      big_man_reg    <= '0;
      small_man_reg  <= '0;
      big_sign_reg   <= 1'b0;
      small_sign_reg <= 1'b0;
      swap_reg       <= 1'b0;
    end else begin
      unique case (state_reg)
        S_IDLE: begin
          if (in_valid) begin
            a_reg <= a;
            b_reg <= b;
          end
        end
        S_CMP: begin
          // Equal exponents keep A as the larger operand.
          swap_reg       <= a_lt_b;
          exp_reg        <= a_lt_b ? exp_b_eff : exp_a_eff;
          big_man_reg    <= a_lt_b ? man_b : man_a;
          small_man_reg  <= a_lt_b ? man_a : man_b;
          big_sign_reg   <= a_lt_b ? b_reg[31] : a_reg[31];
          small_sign_reg <= a_lt_b ? a_reg[31] : b_reg[31];
          remaining_reg  <= shift_k;
        end
        S_SHIFT: begin
          small_man_reg <= shifted_man;
          remaining_reg <= rem_after;
        end
        default: ;
      endcase
    end
  end

  assign out_exp        = exp_reg;
  assign out_big_man    = big_man_reg;
  assign out_small_man  = small_man_reg;
  assign out_big_sign   = big_sign_reg;
  assign out_small_sign = small_sign_reg;
  assign out_swap       = swap_reg;

endmodule
